serializer: RTL



---
 rtl/serializer_pkg.sv | 19 +
 rtl/bit_down_counter.sv | 30 +++
 rtl/serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer: FSM state encoding and counter sizing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package serializer_pkg;

  // Fixed 2-bit encoding, also used by bench monitors.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit counter width: clog2 of the word width, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned bw);
    return (bw <= 2) ? 1 : $clog2(bw);
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with a zero flag; decrements only when enabled.
// Latency: load/decrement visible one cycle after the edge; zero flag follows the count.
// Backpressure: none; enable is the only throttle and the count saturates at zero.
module bit_down_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; decrement stops at zero so the counter never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial shifter, MSB first, optional even-parity trailer (SERIALIZER_PARITY_EN).
// Latency: MSB on serial_out in the cycle after the load edge; one bit per shift_enable tick.
// Backpressure: shift_enable low stalls with outputs held; loads accepted only while ready.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned bitwidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_enable,
  input  logic [bitwidth-1:0] value_in,
  input  logic                shift_enable,
  output logic                ready,
  output logic                serial_out,
  output logic                serial_valid,
  output logic                done
);

  localparam int unsigned   CW       = cnt_width(bitwidth);
  localparam logic [CW-1:0] CNT_LAST = CW'(bitwidth - 1);

  state_t              state;
  // serial_out holds the current bit; rest holds the bits still to come, next one at the top.
  logic [bitwidth-2:0] rest;
  logic                cnt_zero;
`ifdef SERIALIZER_PARITY_EN
  logic                parity_bit;
`endif

  bit_down_counter #(
    .WIDTH(CW)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       ((state == ST_IDLE) && load_enable),
    .load_value (CNT_LAST),
    .enable     ((state == ST_SHIFT) && shift_enable),
    .zero       (cnt_zero)
  );

  // Frame sequencing; every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      rest         <= '0;
      ready        <= 1'b1;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      done         <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_enable) begin
            state        <= ST_SHIFT;
            ready        <= 1'b0;
            serial_out   <= value_in[bitwidth-1];
            serial_valid <= 1'b1;
            rest         <= value_in[bitwidth-2:0];
`ifdef SERIALIZER_PARITY_EN
            parity_bit   <= ^value_in;
`endif
          end
        end
        ST_SHIFT: begin
          if (shift_enable) begin
            rest <= rest << 1;
            if (cnt_zero) begin
`ifdef SERIALIZER_PARITY_EN
              state        <= ST_PARITY;
              serial_out   <= parity_bit;
`else
              state        <= ST_DONE;
              serial_out   <= 1'b0;
              serial_valid <= 1'b0;
              done         <= 1'b1;
`endif
            end else begin
              serial_out <= rest[bitwidth-2];
            end
          end
        end
`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (shift_enable) begin
            state        <= ST_DONE;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done         <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state        <= ST_IDLE;
          ready        <= 1'b1;
          serial_out   <= 1'b0;
          serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
